// File: rtl/pio_link_pkg.sv
// Shared definitions for the 5-bit PIO word link (tx and rx sides).
// Default word width, frame timing and the link FSM state encoding.
package pio_link_pkg;

  localparam int PIO_DATA_W    = 5;
  localparam int PIO_CLK_DIV   = 4;
  localparam int PIO_FRAME_LEN = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_LATCH,
    S_PULSE
  } pio_state_t;

endpackage

// File: rtl/pio_tx_fifo.sv
// Word buffer for the PIO transmitter.
// Synchronous FIFO with level output and registered ready.
module pio_tx_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [LW-1:0] level,
  output logic          ready,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [LW-1:0] level_d;

  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_push = push && ((level != LW'(DEPTH)) || do_pop);
  assign level_d = level + LW'(do_push) - LW'(do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ready  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_d;
      ready <= (level_d != LW'(DEPTH));
    end
  end

endmodule

// File: rtl/pio_word_tx.sv
// Transmit end of the 5-bit PIO word link: FIFO, strobe FSM, frame latch/pulse.
// Define PIO_TX_IDLE_FLUSH_EN to zero-pad a starved frame after FLUSH_CYCLES.
module pio_word_tx
  import pio_link_pkg::*;
#(
  parameter int DATA_W       = PIO_DATA_W,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLK_DIV      = PIO_CLK_DIV,
  parameter int FRAME_LEN    = PIO_FRAME_LEN,
  parameter int FLUSH_CYCLES = 64,
  localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iVALID,
  output logic              oREADY,
  output logic              oBUS_CLK,
  output logic [DATA_W-1:0] oBUS_DAT,
  output logic              oBUS_LATCH,
  output logic              oBUS_PULSE,
  output logic              oBUSY,
  output logic [LW-1:0]     oFIFO_LEVEL
);

  localparam int TW = $clog2(2 * CLK_DIV) + 1;
  localparam int CW = $clog2(FRAME_LEN + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      CLK_DIV < 1 || FRAME_LEN < 1 || FLUSH_CYCLES < 1) begin : g_bad_cfg
    $error("pio_word_tx: illegal parameter set");
  end

  pio_state_t        state, state_d;
  logic [TW-1:0]     timer, timer_d;
  logic [CW-1:0]     count, count_d;
  logic              stall, stall_d;
  logic              pop;
  logic              empty;
  logic              padding;
  logic [DATA_W-1:0] head;
  logic              half_done;
  logic              latch_done;
  logic              last_word;
  logic              clk_d;
  logic              latch_d;
  logic              pulse_d;

  pio_tx_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (iCLK),
    .rst   (iRESET),
    .push  (iVALID && oREADY),
    .wdata (iDATA),
    .pop   (pop),
    .rdata (head),
    .level (oFIFO_LEVEL),
    .ready (oREADY),
    .empty (empty)
  );

  assign half_done  = (timer == TW'(CLK_DIV - 1));
  assign latch_done = (timer == TW'(2 * CLK_DIV - 1));
  assign last_word  = (count == CW'(FRAME_LEN - 1));
  assign oBUSY      = (state != S_IDLE) || !empty;

`ifdef PIO_TX_IDLE_FLUSH_EN
  localparam int SW = $clog2(FLUSH_CYCLES) + 1;
  logic [SW-1:0] starve, starve_d;
  logic          pad, pad_d;
  logic          zero;
  assign padding = pad;
`else
  assign padding = 1'b0;
`endif

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state <= S_IDLE;
      timer <= '0;
      count <= '0;
      stall <= 1'b0;
    end else begin
      state <= state_d;
      timer <= timer_d;
      count <= count_d;
      stall <= stall_d;
    end
  end

`ifdef PIO_TX_IDLE_FLUSH_EN
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      starve <= '0;
      pad    <= 1'b0;
    end else begin
      starve <= starve_d;
      pad    <= pad_d;
    end
  end
`endif

  always_comb begin
    state_d = state;
    timer_d = timer;
    count_d = count;
    stall_d = stall;
    pop     = 1'b0;
`ifdef PIO_TX_IDLE_FLUSH_EN
    starve_d = '0;
    pad_d    = pad;
    zero     = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_SETUP;
          timer_d = '0;
        end
      end
      S_SETUP: begin
        // Stalled: bus frozen until the next word arrives.
        if (stall) begin
          if (!empty) begin
            pop     = 1'b1;
            stall_d = 1'b0;
            timer_d = '0;
          end
`ifdef PIO_TX_IDLE_FLUSH_EN
          else if (starve == SW'(FLUSH_CYCLES - 1)) begin
            stall_d = 1'b0;
            pad_d   = 1'b1;
            zero    = 1'b1;
            timer_d = '0;
          end else begin
            starve_d = starve + 1'b1;
          end
`endif
        end else if (half_done) begin
          state_d = S_STROBE;
          timer_d = '0;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      S_STROBE: begin
        if (half_done) begin
          timer_d = '0;
          count_d = count + 1'b1;
          if (last_word) begin
            state_d = S_LATCH;
          end else begin
            state_d = S_SETUP;
            if (!padding && !empty) begin
              pop = 1'b1;
            end else if (!padding) begin
              stall_d = 1'b1;
            end
          end
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      S_LATCH: begin
        if (latch_done) begin
          state_d = S_PULSE;
          timer_d = '0;
          count_d = '0;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      S_PULSE: begin
        if (half_done) begin
          timer_d = '0;
`ifdef PIO_TX_IDLE_FLUSH_EN
          pad_d = 1'b0;
`endif
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        count_d = '0;
        stall_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    clk_d   = 1'b0;
    latch_d = 1'b0;
    pulse_d = 1'b0;
    case (state_d)
      S_STROBE: clk_d   = 1'b1;
      S_LATCH:  latch_d = 1'b1;
      S_PULSE:  pulse_d = 1'b1;
      default:  clk_d   = 1'b0;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      oBUS_CLK   <= 1'b0;
      oBUS_LATCH <= 1'b0;
      oBUS_PULSE <= 1'b0;
      oBUS_DAT   <= '0;
    end else begin
      oBUS_CLK   <= clk_d;
      oBUS_LATCH <= latch_d;
      oBUS_PULSE <= pulse_d;
      if (pop) begin
        oBUS_DAT <= head;
      end
`ifdef PIO_TX_IDLE_FLUSH_EN
      else if (zero) begin
        oBUS_DAT <= '0;
      end
`endif
    end
  end

endmodule
